countdown_sequencer: RTL and testbench

Generates the pre-game "READY / SET / GO" countdown for the rhythm game and drives the 2-bit `phase` code consumed by the start-text overlay renderer (0=READY, 1=SET, 2=GO, 3=no overlay). It sits between the game-control logic and the VGA overlay path. It advances phases on VGA frame ticks so that text changes are frame-aligned. It also emits one-cycle cue pulses for the audio beeper and a `game_start` pulse that launches note playback.

---
 rtl/countdown_sequencer.sv | 147 ++++++++++++++
 tb/tb_countdown_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: READY / SET / GO pre-game countdown paced by VGA frame
// ticks, with frame-aligned overlay phase, audio cue pulses and a game_start
// pulse that launches note playback.
module countdown_sequencer #(
  parameter int unsigned FRAMES_PER_PHASE = 60,
  parameter int unsigned CNT_W            = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       abort,
  input  logic       game_over,
  output logic [1:0] phase,
  output logic       cue_pulse,
  output logic [1:0] cue_id,
  output logic       game_start,
  output logic       busy,
  output logic       running
);

  localparam logic [1:0] PH_READY = 2'd0;
  localparam logic [1:0] PH_SET   = 2'd1;
  localparam logic [1:0] PH_GO    = 2'd2;
  localparam logic [1:0] PH_NONE  = 2'd3;

  // Counter value at which the next frame tick ends the current phase.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PHASE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_SET   = 3'd2,
    ST_GO    = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             cue_pulse_q, cue_pulse_d;
  logic [1:0]       cue_id_q, cue_id_d;
  logic             game_start_q, game_start_d;
  logic             busy_q, busy_d;
  logic             running_q, running_d;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      phase_q      <= PH_NONE;
      cue_pulse_q  <= 1'b0;
      cue_id_q     <= PH_READY;
      game_start_q <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      cue_pulse_q  <= cue_pulse_d;
      cue_id_q     <= cue_id_d;
      game_start_q <= game_start_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
    end
  end

  // Next-state, counter and next-output logic; outputs are derived from the
  // next state so they appear the cycle after the deciding edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cue_pulse_d  = 1'b0;
    cue_id_d     = cue_id_q;
    game_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d     = ST_READY;
          cue_pulse_d = 1'b1;
          cue_id_d    = PH_READY;
        end
      end
      ST_READY, ST_SET, ST_GO: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (state_q)
              ST_READY: begin
                state_d     = ST_SET;
                cue_pulse_d = 1'b1;
                cue_id_d    = PH_SET;
              end
              ST_SET: begin
                state_d     = ST_GO;
                cue_pulse_d = 1'b1;
                cue_id_d    = PH_GO;
              end
              default: begin
                state_d      = ST_RUN;
                game_start_d = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (abort || game_over) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    phase_d   = PH_NONE;
    busy_d    = 1'b0;
    running_d = 1'b0;
    case (state_d)
      ST_READY: begin phase_d = PH_READY; busy_d = 1'b1; end
      ST_SET:   begin phase_d = PH_SET;   busy_d = 1'b1; end
      ST_GO:    begin phase_d = PH_GO;    busy_d = 1'b1; end
      ST_RUN:   running_d = 1'b1;
      default:  phase_d = PH_NONE;
    endcase
  end

  assign phase      = phase_q;
  assign cue_pulse  = cue_pulse_q;
  assign cue_id     = cue_id_q;
  assign game_start = game_start_q;
  assign busy       = busy_q;
  assign running    = running_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer with FRAMES_PER_PHASE = 2.
module tb_countdown_sequencer;

  localparam int unsigned FPP = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned NV  = 36;

  logic       clk;
  logic       resetn;
  logic       frame_tick, start, abort, game_over;
  logic [1:0] phase, cue_id;
  logic       cue_pulse, game_start, busy, running;

  int n_cmp;
  int n_bad;
  int cue_cnt;
  int gs_cnt;

  countdown_sequencer #(.FRAMES_PER_PHASE(FPP), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .abort(abort), .game_over(game_over), .phase(phase), .cue_pulse(cue_pulse),
    .cue_id(cue_id), .game_start(game_start), .busy(busy), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick, st, ab, gov;
    logic [1:0] ph;
    logic       cue;
    logic [1:0] id;
    logic       gs, bsy, run;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic t, input logic s, input logic a, input logic g,
                              input logic [1:0] ph, input logic cue, input logic [1:0] id,
                              input logic gs, input logic b, input logic r);
    vec_t v;
    v.tick = t; v.st = s; v.ab = a; v.gov = g;
    v.ph = ph; v.cue = cue; v.id = id; v.gs = gs; v.bsy = b; v.run = r;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, sample #1 after the edge, track pulses.
  task automatic step(input logic t, input logic s, input logic a, input logic g);
    frame_tick = t; start = s; abort = a; game_over = g;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; start = 1'b0; abort = 1'b0; game_over = 1'b0;
    if (cue_pulse) cue_cnt++;
    if (game_start) gs_cnt++;
    if (cue_pulse && game_start) chk("cue_gs_overlap", 1, 0);
    if (busy && running) chk("busy_run_overlap", 1, 0);
  endtask

  function automatic int pack_out(input logic [1:0] ph, input logic cue, input logic [1:0] id,
                                  input logic gs, input logic b, input logic r);
    return int'({ph, cue, id, gs, b, r});
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0; cue_cnt = 0; gs_cnt = 0;
    resetn = 1'b0; frame_tick = 1'b0; start = 1'b0; abort = 1'b0; game_over = 1'b0;

    // tick start abort gover | phase cue id gs busy run
    vecs[0]  = mk(1,1,0,0, 2'd0,1,2'd0,0,1,0); // start; coincident tick not counted
    vecs[1]  = mk(0,0,0,0, 2'd0,0,2'd0,0,1,0);
    vecs[2]  = mk(1,0,0,0, 2'd0,0,2'd0,0,1,0); // tick 1
    vecs[3]  = mk(0,1,0,0, 2'd0,0,2'd0,0,1,0); // start ignored in READY
    vecs[4]  = mk(1,0,0,0, 2'd1,1,2'd1,0,1,0); // tick 2 -> SET
    vecs[5]  = mk(1,0,0,0, 2'd1,0,2'd1,0,1,0);
    vecs[6]  = mk(1,0,0,0, 2'd2,1,2'd2,0,1,0); // -> GO
    vecs[7]  = mk(1,1,0,0, 2'd2,0,2'd2,0,1,0); // start ignored in GO
    vecs[8]  = mk(1,0,0,0, 2'd3,0,2'd2,1,0,1); // tick 6 -> RUN, game_start
    vecs[9]  = mk(1,0,0,0, 2'd3,0,2'd2,0,0,1); // tick ignored in RUN
    vecs[10] = mk(0,1,0,0, 2'd3,0,2'd2,0,0,1); // start ignored in RUN
    vecs[11] = mk(0,0,0,1, 2'd3,0,2'd2,0,0,0); // game_over -> IDLE
    vecs[12] = mk(0,1,1,0, 2'd3,0,2'd2,0,0,0); // start+abort: stay IDLE
    vecs[13] = mk(1,0,0,0, 2'd3,0,2'd2,0,0,0); // tick ignored in IDLE
    vecs[14] = mk(0,1,0,0, 2'd0,1,2'd0,0,1,0); // fresh READY, cue_id 0
    vecs[15] = mk(1,0,0,0, 2'd0,0,2'd0,0,1,0);
    vecs[16] = mk(1,0,1,0, 2'd3,0,2'd0,0,0,0); // abort beats READY expiry
    vecs[17] = mk(0,1,0,0, 2'd0,1,2'd0,0,1,0);
    vecs[18] = mk(1,0,0,0, 2'd0,0,2'd0,0,1,0);
    vecs[19] = mk(1,0,0,0, 2'd1,1,2'd1,0,1,0);
    vecs[20] = mk(1,0,0,0, 2'd1,0,2'd1,0,1,0);
    vecs[21] = mk(1,0,1,0, 2'd3,0,2'd1,0,0,0); // abort mid-SET on expiring tick
    vecs[22] = mk(0,1,0,0, 2'd0,1,2'd0,0,1,0);
    vecs[23] = mk(1,0,0,0, 2'd0,0,2'd0,0,1,0);
    vecs[24] = mk(1,0,0,0, 2'd1,1,2'd1,0,1,0);
    vecs[25] = mk(1,0,0,0, 2'd1,0,2'd1,0,1,0);
    vecs[26] = mk(1,0,0,0, 2'd2,1,2'd2,0,1,0);
    vecs[27] = mk(0,0,1,0, 2'd3,0,2'd2,0,0,0); // abort in GO, no game_start
    vecs[28] = mk(0,1,0,0, 2'd0,1,2'd0,0,1,0);
    vecs[29] = mk(1,0,0,0, 2'd0,0,2'd0,0,1,0);
    vecs[30] = mk(1,0,0,0, 2'd1,1,2'd1,0,1,0);
    vecs[31] = mk(1,0,0,0, 2'd1,0,2'd1,0,1,0);
    vecs[32] = mk(1,0,0,0, 2'd2,1,2'd2,0,1,0);
    vecs[33] = mk(1,0,0,0, 2'd2,0,2'd2,0,1,0);
    vecs[34] = mk(1,0,0,0, 2'd3,0,2'd2,1,0,1);
    vecs[35] = mk(0,0,1,1, 2'd3,0,2'd2,0,0,0); // abort+game_over in RUN

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", pack_out(phase, cue_pulse, cue_id, game_start, busy, running),
        pack_out(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    resetn = 1'b1;
    step(0,0,0,0);
    chk("idle_after_rst", pack_out(phase, cue_pulse, cue_id, game_start, busy, running),
        pack_out(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));

    // Table-driven vectors.
    for (int i = 0; i < int'(NV); i++) begin
      step(vecs[i].tick, vecs[i].st, vecs[i].ab, vecs[i].gov);
      n_cmp++;
      if (pack_out(phase, cue_pulse, cue_id, game_start, busy, running) !=
          pack_out(vecs[i].ph, vecs[i].cue, vecs[i].id, vecs[i].gs, vecs[i].bsy, vecs[i].run)) begin
        n_bad++;
        $display("FAIL vec%0d: got ph=%0d cue=%0b id=%0d gs=%0b busy=%0b run=%0b expected ph=%0d cue=%0b id=%0d gs=%0b busy=%0b run=%0b",
                 i, phase, cue_pulse, cue_id, game_start, busy, running,
                 vecs[i].ph, vecs[i].cue, vecs[i].id, vecs[i].gs, vecs[i].bsy, vecs[i].run);
      end
    end

    // Nominal sequence with ticks every 10 cycles.
    cue_cnt = 0; gs_cnt = 0;
    step(0,1,0,0);
    chk("nom_ready_phase", int'(phase), 0);
    for (int p = 0; p < 3; p++) begin
      for (int t = 1; t <= int'(FPP); t++) begin
        for (int q = 0; q < 9; q++) step(0,0,0,0);
        chk($sformatf("nom_pre_tick_p%0d_t%0d", p, t), int'(phase), p);
        step(1,0,0,0);
        chk($sformatf("nom_post_tick_p%0d_t%0d", p, t), int'(phase),
            (t == int'(FPP)) ? p + 1 : p);
      end
    end
    chk("nom_running", int'(running), 1);
    chk("nom_cue_id_last", int'(cue_id), 2);
    for (int q = 0; q < 5; q++) step(0,0,0,0);
    chk("nom_running_hold", int'(running), 1);
    chk("nom_cue_count", cue_cnt, 3);
    chk("nom_gs_count", gs_cnt, 1);
    step(0,0,0,1);
    chk("runexit_phase", int'(phase), 3);
    chk("runexit_running", int'(running), 0);

    // Async reset during GO.
    step(0,1,0,0);
    for (int q = 0; q < 4; q++) step(1,0,0,0);
    chk("pre_rst_go", int'(phase), 2);
    frame_tick = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_outputs", pack_out(phase, cue_pulse, cue_id, game_start, busy, running),
        pack_out(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    resetn = 1'b1;
    gs_cnt = 0; cue_cnt = 0;
    for (int q = 0; q < 6; q++) step(1,0,0,0);
    chk("post_rst_no_gs", gs_cnt, 0);
    chk("post_rst_no_cue", cue_cnt, 0);
    chk("post_rst_phase", int'(phase), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
